// File: rtl/pipe_smac.sv
// Three-stage pipelined signed/unsigned multiply-accumulate unit with valid/ready handshake.
// S1 holds operands, S2 holds the 2N-bit product, S3 holds the result and the accumulator.
module pipe_smac #(
    parameter int unsigned N     = 8,
    parameter int unsigned ACC_W = 2 * N + 8,
    parameter int unsigned SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             is_signed,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow
);

    if (ACC_W < 2 * N + 1) begin : g_acc_w_check
        $error("pipe_smac: ACC_W must be at least 2*N+1");
    end
    if (N < 2) begin : g_n_check
        $error("pipe_smac: N must be at least 2");
    end

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

    logic stall;
    logic adv;

    // Stage 1
    logic         v1_q, v1_d;
    logic [N-1:0] a1_q, a1_d;
    logic [N-1:0] b1_q, b1_d;
    logic         sgn1_q, sgn1_d;
    logic         en1_q, en1_d;
    logic         clr1_q, clr1_d;

    // Stage 2
    logic           v2_q, v2_d;
    logic [2*N-1:0] prod2_q, prod2_d;
    logic           sgn2_q, sgn2_d;
    logic           en2_q, en2_d;
    logic           clr2_q, clr2_d;

    // Stage 3
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    logic [2*N-1:0]   a_ext;
    logic [2*N-1:0]   b_ext;
    logic [2*N-1:0]   prod;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] sum_final;

    // The whole pipeline freezes while the head result waits for the consumer.
    assign stall    = out_valid_q & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;

    always_comb begin
        v1_d   = v1_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        sgn1_d = sgn1_q;
        en1_d  = en1_q;
        clr1_d = clr1_q;
        if (adv) begin
            v1_d = in_valid;
            if (in_valid) begin
                a1_d   = a;
                b1_d   = b;
                sgn1_d = is_signed;
                en1_d  = acc_en;
                clr1_d = acc_clr;
            end
        end
    end

    always_comb begin
        if (sgn1_q) begin
            a_ext = {{N{a1_q[N-1]}}, a1_q};
            b_ext = {{N{b1_q[N-1]}}, b1_q};
        end else begin
            a_ext = {{N{1'b0}}, a1_q};
            b_ext = {{N{1'b0}}, b1_q};
        end
    end

    // Low 2N bits of the 2N x 2N product are exact for both signed and unsigned operands.
    assign prod = a_ext * b_ext;

    always_comb begin
        v2_d    = v2_q;
        prod2_d = prod2_q;
        sgn2_d  = sgn2_q;
        en2_d   = en2_q;
        clr2_d  = clr2_q;
        if (adv) begin
            v2_d = v1_q;
            if (v1_q) begin
                prod2_d = prod;
                sgn2_d  = sgn1_q;
                en2_d   = en1_q;
                clr2_d  = clr1_q;
            end
        end
    end

    always_comb begin
        if (sgn2_q) begin
            prod_ext = {{(ACC_W - 2 * N){prod2_q[2*N-1]}}, prod2_q};
        end else begin
            prod_ext = {{(ACC_W - 2 * N){1'b0}}, prod2_q};
        end
    end

    // acc_q already holds the value left by the previous acc beat, so dependent beats need no bubble.
    assign acc_base = clr2_q ? '0 : acc_q;
    assign sum      = {acc_base[ACC_W-1], acc_base} + {prod_ext[ACC_W-1], prod_ext};
    assign sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        sum_final = sum[ACC_W-1:0];
        if (sum_ovf && (SAT != 0)) begin
            sum_final = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        acc_d       = acc_q;
        if (adv) begin
            out_valid_d = v2_q;
            if (v2_q) begin
                if (en2_q) begin
                    result_d   = sum_final;
                    overflow_d = sum_ovf;
                    acc_d      = sum_final;
                end else begin
                    result_d   = prod_ext;
                    overflow_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            a1_q        <= '0;
            b1_q        <= '0;
            sgn1_q      <= 1'b0;
            en1_q       <= 1'b0;
            clr1_q      <= 1'b0;
            v2_q        <= 1'b0;
            prod2_q     <= '0;
            sgn2_q      <= 1'b0;
            en2_q       <= 1'b0;
            clr2_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            acc_q       <= '0;
        end else begin
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            sgn1_q      <= sgn1_d;
            en1_q       <= en1_d;
            clr1_q      <= clr1_d;
            v2_q        <= v2_d;
            prod2_q     <= prod2_d;
            sgn2_q      <= sgn2_d;
            en2_q       <= en2_d;
            clr2_q      <= clr2_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_pipe_smac.sv
// Self-checking bench for pipe_smac: saturating and wrapping instances share one stimulus stream
// and are compared every output cycle against an arithmetic model of the accepted beats.
module tb_pipe_smac;
    localparam int N     = 8;
    localparam int ACC_W = 24;
    localparam longint LIM_HI = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint LIM_LO = -(64'sd1 <<< (ACC_W - 1));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [N-1:0]     a = '0;
    logic [N-1:0]     b = '0;
    logic             is_signed = 1'b0;
    logic             acc_en = 1'b0;
    logic             acc_clr = 1'b0;
    logic             out_ready = 1'b1;
    logic             in_ready, in_ready_w;
    logic             out_valid, out_valid_w;
    logic [ACC_W-1:0] result, result_w;
    logic             overflow, overflow_w;

    pipe_smac #(.N(N), .ACC_W(ACC_W), .SAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow)
    );

    pipe_smac #(.N(N), .ACC_W(ACC_W), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b),
        .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(out_valid_w),
        .out_ready(out_ready), .result(result_w), .overflow(overflow_w)
    );

    typedef struct {longint rs; bit os; longint rw; bit ow;} exp_t;
    typedef struct {longint rs; bit os; longint rw; bit ow; int cyc;} obs_t;

    exp_t   exp_q[$];
    obs_t   obs_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    longint acc_s = 0;
    longint acc_w = 0;
    longint p, s;
    exp_t   e;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic longint wrapw(input longint v);
        longint m;
        m = v & ((64'sd1 <<< ACC_W) - 1);
        if (m > LIM_HI) m = m - (64'sd1 <<< ACC_W);
        return m;
    endfunction

    function automatic longint opnd(input logic [N-1:0] v, input logic sgn);
        return sgn ? longint'($signed(v)) : longint'(v);
    endfunction

    // Model: every accepted beat's expected outputs, in acceptance order.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            acc_s = 0;
            acc_w = 0;
        end else begin
            chk("inst_agree_valid", longint'({out_valid_w, in_ready_w}),
                longint'({out_valid, in_ready}));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    chk("result_sat", longint'($signed(result)), exp_q[0].rs);
                    chk("overflow_sat", longint'(overflow), longint'(exp_q[0].os));
                    chk("result_wrap", longint'($signed(result_w)), exp_q[0].rw);
                    chk("overflow_wrap", longint'(overflow_w), longint'(exp_q[0].ow));
                    if (out_ready) begin
                        obs_q.push_back('{longint'($signed(result)), overflow,
                                          longint'($signed(result_w)), overflow_w, cyc});
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                p = opnd(a, is_signed) * opnd(b, is_signed);
                if (!acc_en) begin
                    e = '{p, 1'b0, p, 1'b0};
                end else begin
                    s = (acc_clr ? 0 : acc_s) + p;
                    e.os = (s > LIM_HI) || (s < LIM_LO);
                    e.rs = (s > LIM_HI) ? LIM_HI : ((s < LIM_LO) ? LIM_LO : s);
                    acc_s = e.rs;
                    s = (acc_clr ? 0 : acc_w) + p;
                    e.ow = (s > LIM_HI) || (s < LIM_LO);
                    e.rw = wrapw(s);
                    acc_w = e.rw;
                end
                exp_q.push_back(e);
            end
        end
    end

    // Presents a beat and returns #1 after the edge that accepted it; in_valid stays high.
    task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic sgn,
                        input logic en, input logic clr);
        bit ok;
        int n;
        a = ta; b = tb; is_signed = sgn; acc_en = en; acc_clr = clr; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", longint'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     cnt;
        int     nov;
        longint ref_sum;
        logic [N-1:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_result", longint'(result), 0);
        chk("reset_overflow", longint'(overflow), 0);
        chk("reset_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: latency counted in rising edges, accept edge included.
        send(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            cnt++;
        end
        chk("t1_latency", cnt, 3);
        chk("t1_result", longint'($signed(result)), 16384);
        chk("t1_overflow", longint'(overflow), 0);
        drain();

        // T2
        obs_q.delete();
        send(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        drain();
        chk("t2_count", obs_q.size(), 2);
        chk("t2_unsigned", obs_q[0].rs, 65025);
        chk("t2_signed", obs_q[1].rs, 1);

        // T3
        obs_q.delete();
        send(8'd3, 8'd4, 1'b1, 1'b1, 1'b1);
        send(8'hFE, 8'd5, 1'b1, 1'b1, 1'b0);
        send(8'd7, 8'hFF, 1'b1, 1'b1, 1'b0);
        drain();
        chk("t3_count", obs_q.size(), 3);
        chk("t3_r0", obs_q[0].rs, 12);
        chk("t3_r1", obs_q[1].rs, 2);
        chk("t3_r2", obs_q[2].rs, -5);
        chk("t3_gap01", obs_q[1].cyc - obs_q[0].cyc, 1);
        chk("t3_gap12", obs_q[2].cyc - obs_q[1].cyc, 1);

        // T4: 512 x 16384 = 2^23, one past the positive limit.
        obs_q.delete();
        for (int i = 0; i < 512; i++) send(8'h80, 8'h80, 1'b1, 1'b1, i == 0);
        drain();
        chk("t4_count", obs_q.size(), 512);
        nov = 0;
        for (int i = 0; i < 511; i++) nov += int'(obs_q[i].os) + int'(obs_q[i].ow);
        chk("t4_no_early_ovf", nov, 0);
        chk("t4_r511", obs_q[510].rs, 8372224);
        chk("t4_sat_result", obs_q[511].rs, 8388607);
        chk("t4_sat_ovf", longint'(obs_q[511].os), 1);
        chk("t4_wrap_result", obs_q[511].rw, -8388608);
        chk("t4_wrap_ovf", longint'(obs_q[511].ow), 1);

        // T5: backpressure pattern 1,0,0 repeating while 10 acc beats stream in.
        obs_q.delete();
        ref_sum = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    ra = 8'($urandom_range(0, 15) - 8);
                    rb = 8'($urandom_range(0, 15) - 8);
                    ref_sum += longint'($signed(ra)) * longint'($signed(rb));
                    send(ra, rb, 1'b1, 1'b1, i == 0);
                end
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    out_ready = (k % 3) == 0;
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();
        chk("t5_count", obs_q.size(), 10);
        chk("t5_total", obs_q[9].rs, ref_sum);

        // T6: reset with three acc beats in flight.
        send(8'd5, 8'd5, 1'b1, 1'b1, 1'b1);
        send(8'd6, 8'd6, 1'b1, 1'b1, 1'b0);
        send(8'd7, 8'd7, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", longint'(out_valid), 0);
        chk("t6_result", longint'(result), 0);
        @(posedge clk);
        #1;
        obs_q.delete();
        send(8'd2, 8'd3, 1'b1, 1'b1, 1'b0);
        drain();
        chk("t6_count", obs_q.size(), 1);
        chk("t6_post_reset", obs_q[0].rs, 6);

        // Random mixed traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 4))
                0: a = 8'h80;
                1: a = 8'h7F;
                2: a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            b         = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h80;
            is_signed = 1'($urandom);
            acc_en    = ($urandom_range(0, 3) != 0);
            acc_clr   = ($urandom_range(0, 40) == 0);
            @(posedge clk);
            #1;
        end
        drain();

        // Random traffic biased towards positive saturation, with stalls.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = 8'h80;
            b         = ($urandom_range(0, 9) != 0) ? 8'h80 : 8'h7F;
            is_signed = 1'b1;
            acc_en    = 1'b1;
            acc_clr   = ($urandom_range(0, 999) == 0);
            @(posedge clk);
            #1;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
